// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: core request/response handshake plus MAB/MDB memory bus signals.
interface mem_bus_master_if;
  logic        req_valid, req_ready, req_we, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] MAB, MDB_wr, MDB_rd;
  logic        MW, BW;
  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_byte, MDB_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, MAB, MDB_wr, MW, BW
  );
  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_byte, MDB_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, MAB, MDB_wr, MW, BW
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: MAB/MDB bus initiator with fixed wait states and byte-lane steering.
// Define MEM_BUS_ALIGN_CHECK_EN to reject misaligned word accesses with rsp_err.
module mem_bus_master #(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] RESET_MAB   = 16'h0000
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_master_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state, nxt;
  logic [2:0]  cnt;
  logic        rdy, we, is_byte, a0, accept, last, bad;
  logic [15:0] mab, wdat, rdata;
  assign accept = rdy && bus.req_valid;
  assign last = (state == ACCESS && WAIT_STATES == 0) || (state == WAIT && cnt == 3'd0);
  assign nxt = state == IDLE ? (accept ? (bad ? RESP : ACCESS) : IDLE) :
               state == RESP ? IDLE : last ? RESP : WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      rdy     <= 1'b0;
      cnt     <= 3'd0;
      we      <= 1'b0;
      is_byte <= 1'b0;
      a0      <= 1'b0;
      mab     <= RESET_MAB;
      wdat    <= 16'h0;
      rdata   <= 16'h0;
    end else begin
      state <= nxt;
      rdy   <= nxt == IDLE;
      cnt   <= state == ACCESS ? 3'(WAIT_STATES - 1) : cnt - 3'd1;
      if (accept && !bad) begin
        we      <= bus.req_we;
        is_byte <= bus.req_byte;
        a0      <= bus.req_addr[0];
        mab     <= bus.req_byte ? bus.req_addr : {bus.req_addr[15:1], 1'b0};
        wdat    <= bus.req_byte ? {2{bus.req_wdata[7:0]}} : bus.req_wdata;
      end else if (state == RESP) begin
        is_byte <= 1'b0;
        mab     <= RESET_MAB;
        wdat    <= 16'h0;
      end
      if (accept && bad) rdata <= 16'h0;
      else if (last) rdata <= we ? 16'h0 : !is_byte ? bus.MDB_rd :
                              {8'h00, a0 ? bus.MDB_rd[15:8] : bus.MDB_rd[7:0]};
    end
`ifdef MEM_BUS_ALIGN_CHECK_EN
  logic err;
  assign bad = !bus.req_byte && bus.req_addr[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (accept && bad) err <= 1'b1;
    else if (last) err <= 1'b0;
  assign bus.rsp_err = err;
`else
  assign bad = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  assign bus.req_ready = rdy;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.MAB       = mab;
  assign bus.MDB_wr    = wdat;
  assign bus.MW        = last && we;
  assign bus.BW        = is_byte;
endmodule
